ledr_bar_arbiter: RTL and testbench
===================================

# ledr_bar_arbiter

Time-shares the 10-LED red bar between three client requesters using round-robin arbitration. When no client owns the bar, it shows a built-in idle pattern. Each client gets exclusive ownership for a bounded number of prescaled ticks, followed by a one-tick blank gap before the next grant. The block sits between the board-level LED pins and the status/debug clients that want to display 10-bit values.

## Interface
Parameters:
- TICK_DIV, 21'd1048576: iCLK cycles per tick. Must be ≥ 2.
- HOLD_TICKS, 8'd16: maximum number of ticks one grant may last. Must be ≥ 1.

Ports:
- iCLK  input  1  system clock; all logic is on its rising edge.
- iRST  input  1  reset, asynchronous, active-high.
- iREQ  input  3  per-client request, level-sensitive. Bit k belongs to client k.
- iDATA0  input  10  LED value from client 0.
- iDATA1  input  10  LED value from client 1.
- iDATA2  input  10  LED value from client 2.
- oGNT  output  3  one-hot grant, registered. At most one bit is set.
- oBUSY  output  1  high while in GRANT or GAP.
- oLED  output  10  registered LED bar drive.

## Operation
- **Prescaler:** a free-running counter 0..TICK_DIV-1. The tick pulse is high for one cycle when the counter equals TICK_DIV-1; the counter then wraps to 0. The prescaler is never held or cleared except by reset.
- **State IDLE:**
  - oGNT = 0, oBUSY = 0. oLED shows the idle pattern (see Configuration).
  - Any iREQ bit set: go to GRANT for the round-robin winner on the next edge. No tick is needed.
- **Round-robin:**
  - pointer P (2 bits, values 0..2). Search order is P, P+1, P+2 mod 3.
  - On each grant to client k, P becomes (k+1) mod 3.
- **State GRANT(k):**
  - oGNT[k] = 1, oBUSY = 1.
  - oLED = iDATAk, re-registered every cycle, so a change on iDATAk appears on oLED one cycle later.
  - A hold counter starts at 0 on entry and increments on each tick.
  - Exit to GAP when either:
    - iREQ[k] = 0, checked every cycle; or
    - a tick arrives while the hold count equals HOLD_TICKS-1.
- **State GAP:**
  - oGNT = 0, oBUSY = 1, oLED = 0.
  - Stay until the next tick. At that tick:
    - if any iREQ bit is set, go to GRANT for the RR winner (no pass through IDLE);
    - otherwise go to IDLE.
- **Client behaviour:** a client that keeps iREQ high is re-granted only after the other pending clients have been served. The clients have no way to preempt a grant.

## Timing
- **Reset values:**
  - state = IDLE, P = 0, hold = 0, prescaler = 0.
  - oGNT = 3'b000, oBUSY = 0.
  - oLED = 10'b0000000111 with the chaser compiled in, 10'b0 without it.
- **Request to grant:** iREQ sampled high in IDLE at edge N gives oGNT and oBUSY high after edge N+1. oLED = iDATAk after edge N+2.
- **Release:** iREQ[k] sampled low at edge N gives oGNT = 0 and oLED = 0 after edge N+1.
- **Simultaneous tick and request drop:** the request drop wins; the block goes to GAP and the hold counter does not matter.
- **Maximum grant length:** HOLD_TICKS ticks. The first tick counts even if it arrives one cycle after entry.
- **Reset mid-grant:** all state returns to reset values immediately. Reset is asynchronous; deassertion is expected to be synchronous to iCLK.

## Configuration
- Macro: LEDR_ARB_CHASER_EN.
- **Defined:** in IDLE, a 3-LED block bounces across the bar, moving one position per tick.
  - The block starts at bits [2:0] and moves left to [9:7], then right back to [2:0], and repeats.
  - The direction flips on the same tick that reaches an end position.
  - The chaser position is frozen while the bar is granted and resumes where it left off on return to IDLE.
- **Undefined:** the chaser logic is absent, and oLED = 0 in IDLE.

## Test plan
All scenarios use TICK_DIV = 4 and HOLD_TICKS = 3.
1. Reset with iREQ = 0: oGNT = 0, oBUSY = 0, oLED = 0x007. With the chaser compiled in, oLED shows 0x00E after the first tick, then 0x01C, and so on; the direction reverses at 0x380.
2. iREQ = 3'b010 with iDATA1 = 0x2A5: oGNT = 3'b010 one cycle later and oLED = 0x2A5 two cycles later. The grant releases after the 3rd tick, then 0 is shown for the one gap tick, then the block returns to IDLE.
3. iREQ = 3'b111 held with P = 0: the grant sequence is 001, 010, 100, 001. Each grant lasts 3 ticks, with a GAP between grants and no IDLE between them.
4. Client 2 granted, then iREQ[2] dropped in the same cycle as a tick: oGNT = 0 next cycle and the state is GAP. The next grant goes to client 0 if it is requesting.
5. iRST asserted mid-GRANT for 1 cycle with no clock edge: outputs immediately return to reset values, and P = 0.
6. With LEDR_ARB_CHASER_EN undefined: oLED stays at 0 in IDLE for 20 ticks.

Source files
------------

// File: rtl/ledr_bar_arbiter.sv
// ledr_bar_arbiter
//
// Purpose:
//   Round-robin time-sharing of the 10-LED red bar between three clients.
//   A client owns the bar for at most HOLD_TICKS prescaled ticks, or until it
//   drops its request. Every grant is followed by a blank gap that lasts until
//   the next tick. While nobody owns the bar, an idle pattern is shown.
//
// Optional feature (macro LEDR_ARB_CHASER_EN):
//   Defined   : the idle pattern is a 3-LED block that bounces across the bar,
//               moving one position per tick while idle.
//   Undefined : the idle pattern is all LEDs off.
//
// Parameters:
//   TICK_DIV   - iCLK cycles per tick (>= 2)
//   HOLD_TICKS - maximum ticks per grant (>= 1)
//
// Ports:
//   iCLK           - system clock, rising edge
//   iRST           - asynchronous active-high reset
//   iREQ[2:0]      - level-sensitive request, bit k belongs to client k
//   iDATA0..iDATA2 - 10-bit LED value offered by each client
//   oGNT[2:0]      - registered one-hot grant
//   oBUSY          - registered, high while granting or in the gap
//   oLED[9:0]      - registered LED bar drive
module ledr_bar_arbiter #(
  parameter logic [20:0] TICK_DIV   = 21'd1048576,
  parameter logic [7:0]  HOLD_TICKS = 8'd16
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [2:0] iREQ,
  input  logic [9:0] iDATA0,
  input  logic [9:0] iDATA1,
  input  logic [9:0] iDATA2,
  output logic [2:0] oGNT,
  output logic       oBUSY,
  output logic [9:0] oLED
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } state_t;

`ifdef LEDR_ARB_CHASER_EN
  localparam logic [9:0] IDLE_RESET_LED = 10'b0000000111;
`else
  localparam logic [9:0] IDLE_RESET_LED = 10'b0000000000;
`endif

  state_t      r_state;
  state_t      w_stateNext;
  logic [1:0]  r_owner;
  logic [1:0]  w_ownerNext;
  logic [1:0]  r_ptr;
  logic [1:0]  w_ptrNext;
  logic [7:0]  r_hold;
  logic [7:0]  w_holdNext;
  logic [20:0] r_preCnt;
  logic        w_tick;
  logic [2:0]  w_reqRot;
  logic [1:0]  w_winner;
  logic        w_ownerReq;
  logic [9:0]  w_ownerData;
  logic [2:0]  w_ownerOneHot;
  logic [9:0]  w_idleLed;
  logic [2:0]  r_gnt;
  logic        r_busy;
  logic [9:0]  r_led;

  function automatic logic [1:0] nextClient(input logic [1:0] k);
    return (k == 2'd2) ? 2'd0 : k + 2'd1;
  endfunction

  // Free-running prescaler; the tick is the last count before wrapping, and
  // only reset ever disturbs the count.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_preCnt <= '0;
    end else if (r_preCnt == TICK_DIV - 21'd1) begin
      r_preCnt <= '0;
    end else begin
      r_preCnt <= r_preCnt + 21'd1;
    end
  end

  assign w_tick = (r_preCnt == TICK_DIV - 21'd1);

  // The request vector is rotated so bit 0 is the client the pointer favours;
  // the winner is then the first set bit in fixed order, with no variable index.
  always_comb begin
    w_reqRot = iREQ;
    w_winner = r_ptr;
    case (r_ptr)
      2'd1:    w_reqRot = {iREQ[0], iREQ[2], iREQ[1]};
      2'd2:    w_reqRot = {iREQ[1], iREQ[0], iREQ[2]};
      default: w_reqRot = iREQ;
    endcase
    if (w_reqRot[0]) begin
      w_winner = r_ptr;
    end else if (w_reqRot[1]) begin
      w_winner = nextClient(r_ptr);
    end else begin
      w_winner = nextClient(nextClient(r_ptr));
    end
  end

  // Per-owner views: its request bit, its data and its one-hot grant code.
  always_comb begin
    w_ownerReq    = iREQ[2];
    w_ownerData   = iDATA2;
    w_ownerOneHot = 3'b100;
    case (r_owner)
      2'd0: begin
        w_ownerReq    = iREQ[0];
        w_ownerData   = iDATA0;
        w_ownerOneHot = 3'b001;
      end
      2'd1: begin
        w_ownerReq    = iREQ[1];
        w_ownerData   = iDATA1;
        w_ownerOneHot = 3'b010;
      end
      default: begin
        w_ownerReq    = iREQ[2];
        w_ownerData   = iDATA2;
        w_ownerOneHot = 3'b100;
      end
    endcase
  end

  // Next-state logic. A dropped request is tested before the tick so it wins
  // when both happen together. The hold count reaching HOLD_TICKS-1 on a tick
  // ends the grant, so the grant spans exactly HOLD_TICKS ticks.
  always_comb begin
    w_stateNext = r_state;
    w_ownerNext = r_owner;
    w_ptrNext   = r_ptr;
    w_holdNext  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (|iREQ) begin
          w_stateNext = ST_GRANT;
          w_ownerNext = w_winner;
          w_ptrNext   = nextClient(w_winner);
          w_holdNext  = 8'd0;
        end
      end
      ST_GRANT: begin
        if (!w_ownerReq) begin
          w_stateNext = ST_GAP;
        end else if (w_tick) begin
          if (r_hold == HOLD_TICKS - 8'd1) begin
            w_stateNext = ST_GAP;
          end else begin
            w_holdNext = r_hold + 8'd1;
          end
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          if (|iREQ) begin
            w_stateNext = ST_GRANT;
            w_ownerNext = w_winner;
            w_ptrNext   = nextClient(w_winner);
            w_holdNext  = 8'd0;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_IDLE;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
      r_hold  <= 8'd0;
    end else begin
      r_state <= w_stateNext;
      r_owner <= w_ownerNext;
      r_ptr   <= w_ptrNext;
      r_hold  <= w_holdNext;
    end
  end

`ifdef LEDR_ARB_CHASER_EN
  logic [2:0] r_chasePos;
  logic       r_chaseLeft;
  logic [2:0] w_chasePosNext;
  logic       w_chaseLeftNext;

  // Bouncing idle block: position 0 is bits [2:0], position 7 is bits [9:7].
  // The direction flips on the same tick that lands on an end position, and
  // the block only moves while idle so it resumes where it stopped.
  always_comb begin
    w_chasePosNext  = r_chasePos;
    w_chaseLeftNext = r_chaseLeft;
    if ((r_state == ST_IDLE) && w_tick) begin
      if (r_chaseLeft) begin
        w_chasePosNext = r_chasePos + 3'd1;
        if (r_chasePos == 3'd6) begin
          w_chaseLeftNext = 1'b0;
        end
      end else begin
        w_chasePosNext = r_chasePos - 3'd1;
        if (r_chasePos == 3'd1) begin
          w_chaseLeftNext = 1'b1;
        end
      end
    end
  end

  // Chaser position register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_chasePos  <= 3'd0;
      r_chaseLeft <= 1'b1;
    end else begin
      r_chasePos  <= w_chasePosNext;
      r_chaseLeft <= w_chaseLeftNext;
    end
  end

  assign w_idleLed = IDLE_RESET_LED << w_chasePosNext;
`else
  assign w_idleLed = 10'b0000000000;
`endif

  // Registered outputs decoded from the current state. On the first cycle of a
  // grant the registered grant is still clear, so the bar stays blank one more
  // cycle and client data appears from the second grant cycle onwards.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_gnt  <= 3'b000;
      r_busy <= 1'b0;
      r_led  <= IDLE_RESET_LED;
    end else begin
      r_busy <= (r_state != ST_IDLE);
      r_gnt  <= (r_state == ST_GRANT) ? w_ownerOneHot : 3'b000;
      case (r_state)
        ST_GRANT: r_led <= (|r_gnt) ? w_ownerData : 10'b0000000000;
        ST_GAP:   r_led <= 10'b0000000000;
        default:  r_led <= w_idleLed;
      endcase
    end
  end

  assign oGNT  = r_gnt;
  assign oBUSY = r_busy;
  assign oLED  = r_led;

endmodule

// File: tb/tb_ledr_bar_arbiter.sv
module tb_ledr_bar_arbiter;

  localparam int TICK_DIV_I = 4;
  localparam int HOLD_I     = 3;

`ifdef LEDR_ARB_CHASER_EN
  localparam bit CHASER = 1'b1;
`else
  localparam bit CHASER = 1'b0;
`endif

  logic       iCLK;
  logic       iRST;
  logic [2:0] iREQ;
  logic [9:0] iDATA0;
  logic [9:0] iDATA1;
  logic [9:0] iDATA2;
  logic [2:0] oGNT;
  logic       oBUSY;
  logic [9:0] oLED;

  int checks = 0;
  int errors = 0;

  ledr_bar_arbiter #(
    .TICK_DIV  (21'd4),
    .HOLD_TICKS(8'd3)
  ) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iREQ  (iREQ),
    .iDATA0(iDATA0),
    .iDATA1(iDATA1),
    .iDATA2(iDATA2),
    .oGNT  (oGNT),
    .oBUSY (oBUSY),
    .oLED  (oLED)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Idle pattern as a triangle wave over the number of idle ticks seen:
  // positions 0..7..1 repeat with period 14.
  function automatic logic [9:0] idlePattern(input int steps);
    int s;
    int pos;
    logic [9:0] base;
    if (!CHASER) return 10'h000;
    base = 10'h007;
    s = steps % 14;
    pos = (s <= 7) ? s : 14 - s;
    return base << pos;
  endfunction

  // Reference model: behaviour described as modes, tick counts since reset and
  // the age of the current grant; it yields the outputs after each edge.
  typedef enum int {M_IDLE, M_GRANT, M_GAP} mMode_t;

  typedef struct {
    mMode_t     mode;
    int         owner;
    int         ptr;
    int         heldTicks;
    int         grantAge;
    int         chaseSteps;
    int         cycles;
    logic [2:0] gnt;
    logic       busy;
    logic [9:0] led;
  } model_t;

  model_t mState;

  function automatic int pickWinner(input int ptr, input logic [2:0] req);
    for (int i = 0; i < 3; i++) begin
      if (req[(ptr + i) % 3]) return (ptr + i) % 3;
    end
    return ptr;
  endfunction

  function automatic model_t modelReset();
    model_t r;
    r.mode       = M_IDLE;
    r.owner      = 0;
    r.ptr        = 0;
    r.heldTicks  = 0;
    r.grantAge   = 0;
    r.chaseSteps = 0;
    r.cycles     = 0;
    r.gnt        = 3'b000;
    r.busy       = 1'b0;
    r.led        = idlePattern(0);
    return r;
  endfunction

  function automatic model_t modelNext(input model_t c, input logic [2:0] req,
                                       input logic [9:0] d0, input logic [9:0] d1,
                                       input logic [9:0] d2);
    model_t n;
    logic [9:0] data [3];
    bit tick;
    n = c;
    data[0] = d0;
    data[1] = d1;
    data[2] = d2;
    tick = ((c.cycles % TICK_DIV_I) == TICK_DIV_I - 1);
    n.cycles = c.cycles + 1;
    n.gnt  = (c.mode == M_GRANT) ? 3'(1 << c.owner) : 3'b000;
    n.busy = (c.mode != M_IDLE);
    case (c.mode)
      M_IDLE: begin
        if (tick) n.chaseSteps = c.chaseSteps + 1;
        n.led = idlePattern(n.chaseSteps);
        if (req != 3'b000) begin
          n.owner = pickWinner(c.ptr, req);
          n.ptr = (n.owner + 1) % 3;
          n.mode = M_GRANT;
          n.heldTicks = 0;
          n.grantAge = 0;
        end
      end
      M_GRANT: begin
        n.led = (c.grantAge >= 1) ? data[c.owner] : 10'h000;
        n.grantAge = c.grantAge + 1;
        if (!req[c.owner]) begin
          n.mode = M_GAP;
        end else if (tick) begin
          n.heldTicks = c.heldTicks + 1;
          if (n.heldTicks == HOLD_I) n.mode = M_GAP;
        end
      end
      default: begin
        n.led = 10'h000;
        if (tick) begin
          if (req != 3'b000) begin
            n.owner = pickWinner(c.ptr, req);
            n.ptr = (n.owner + 1) % 3;
            n.mode = M_GRANT;
            n.heldTicks = 0;
            n.grantAge = 0;
          end else begin
            n.mode = M_IDLE;
          end
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) mState <= modelReset();
    else      mState <= modelNext(mState, iREQ, iDATA0, iDATA1, iDATA2);
  end

  task automatic applyStimulus(input logic [2:0] req, input logic [9:0] d0,
                               input logic [9:0] d1, input logic [9:0] d2);
    iREQ   = req;
    iDATA0 = d0;
    iDATA1 = d1;
    iDATA2 = d2;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] eg,
                             input logic eb, input logic [9:0] el);
    checks++;
    if (oGNT !== eg) begin
      errors++;
      $display("[TB] FAIL %s oGNT got %b expected %b at %0t", name, oGNT, eg, $time);
    end
    checks++;
    if (oBUSY !== eb) begin
      errors++;
      $display("[TB] FAIL %s oBUSY got %b expected %b at %0t", name, oBUSY, eb, $time);
    end
    checks++;
    if (oLED !== el) begin
      errors++;
      $display("[TB] FAIL %s oLED got %h expected %h at %0t", name, oLED, el, $time);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mState.gnt, mState.busy, mState.led);
  endtask

  task automatic doReset();
    @(negedge iCLK);
    iRST = 1'b1;
    iREQ = 3'b000;
    @(negedge iCLK);
    checkOutput("reset", 3'b000, 1'b0, idlePattern(0));
    iRST = 1'b0;
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] gnt;
    logic       busy;
    logic [9:0] led;
  } vec_t;

  vec_t       vecs [20];
  logic [2:0] rrExp [4];
  logic [2:0] seen [$];
  logic [2:0] prevG;
  int         holdLeft;

  initial begin
    // Single client 1 request with iDATA1 = 0x2A5, released by the hold limit
    // after the third tick, request dropped afterwards.
    for (int i = 0; i < 20; i++) begin
      vecs[i].req  = (i < 12) ? 3'b010 : 3'b000;
      vecs[i].gnt  = (i >= 1 && i <= 11) ? 3'b010 : 3'b000;
      vecs[i].busy = (i >= 1 && i <= 15);
      if (i == 0 || (i >= 16 && i <= 18)) vecs[i].led = idlePattern(0);
      else if (i == 19)                    vecs[i].led = idlePattern(1);
      else if (i >= 2 && i <= 11)          vecs[i].led = 10'h2A5;
      else                                 vecs[i].led = 10'h000;
    end
    rrExp[0] = 3'b001;
    rrExp[1] = 3'b010;
    rrExp[2] = 3'b100;
    rrExp[3] = 3'b001;

    iRST = 1'b1;
    applyStimulus(3'b000, 10'h000, 10'h000, 10'h000);
    repeat (2) @(posedge iCLK);

    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].req, 10'h3FF, 10'h2A5, 10'h001);
      @(negedge iCLK);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].led);
    end

    // All three clients requesting: grants rotate 001, 010, 100, 001.
    doReset();
    prevG = 3'b000;
    for (int c = 0; c < 64; c++) begin
      applyStimulus(3'b111, 10'h111, 10'h222, 10'h333);
      @(negedge iCLK);
      checkModel("rr_model");
      if (oGNT != 3'b000 && prevG == 3'b000) seen.push_back(oGNT);
      prevG = oGNT;
    end
    checks++;
    if (seen.size() < 4) begin
      errors++;
      $display("[TB] FAIL rr_count got %0d grants expected at least 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== rrExp[i]) begin
          errors++;
          $display("[TB] FAIL rr_order%0d got %b expected %b", i, seen[i], rrExp[i]);
        end
      end
    end

    // Client 2 drops its request on the same edge as a tick while client 0 asks.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i < 3) ? 3'b100 : 3'b001, 10'h0F0, 10'h00F, 10'h3C3);
      @(negedge iCLK);
      checkModel("drop_model");
      if (i == 4) checkOutput("drop_gap", 3'b000, 1'b1, 10'h000);
      if (i == 8) checkOutput("drop_next", 3'b001, 1'b1, 10'h000);
    end

    // Asynchronous reset between edges during a grant, then pointer back at 0.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b010, 10'h000, 10'h155, 10'h000);
      @(negedge iCLK);
      checkModel("pre_async");
    end
    #1 iRST = 1'b1;
    #1 checkOutput("async_reset", 3'b000, 1'b0, idlePattern(0));
    #1 iRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b110, 10'h000, 10'h155, 10'h2AA);
      @(negedge iCLK);
      checkModel("post_async");
      if (i == 1) checkOutput("ptr_reset", 3'b010, 1'b1, 10'h000);
    end

    // Long idle stretch: chaser bounce (or a dark bar) over more than 20 ticks.
    doReset();
    for (int i = 0; i < 90; i++) begin
      applyStimulus(3'b000, 10'h3FF, 10'h3FF, 10'h3FF);
      @(negedge iCLK);
      checkModel("idle_model");
    end

    // Randomized traffic against the reference model.
    holdLeft = 0;
    for (int c = 0; c < 1500; c++) begin
      if (holdLeft == 0) begin
        iREQ = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
        holdLeft = $urandom_range(1, 30);
      end
      holdLeft--;
      if ($urandom_range(0, 3) == 0) iDATA0 = 10'($urandom);
      if ($urandom_range(0, 3) == 0) iDATA1 = 10'($urandom);
      if ($urandom_range(0, 3) == 0) iDATA2 = 10'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #1 iRST = 1'b1;
        #1 checkOutput("rnd_async_reset", 3'b000, 1'b0, idlePattern(0));
        #1 iRST = 1'b0;
      end
      @(negedge iCLK);
      checkModel("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
